// File: rtl/pwm_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_gen_multi
// Brief    : N-channel PWM, one shared counter, double-buffered period/duty.
//            Macro PWM_CENTER_ALIGN_EN selects an up/down (centre-aligned) counter.
// Revision : 1.0
// ============================================================================
module pwm_gen_multi #(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 8,
  parameter int CH_W     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CNT_W-1:0]    period,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [CNT_W-1:0]    wr_duty,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_end
);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    period_act_q, period_act_d;
  logic [CNT_W-1:0]    duty_sh_q  [CHANNELS];
  logic [CNT_W-1:0]    duty_sh_d  [CHANNELS];
  logic [CNT_W-1:0]    duty_act_q [CHANNELS];
  logic [CNT_W-1:0]    duty_act_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_end_q, period_end_d;
  logic                boundary;
`ifdef PWM_CENTER_ALIGN_EN
  logic                dir_q, dir_d;   // 0 = counting up, 1 = counting down
  logic                en_q, en_d;
`endif

  always_comb begin
    cnt_d        = cnt_q;
    period_act_d = period_act_q;
    period_end_d = 1'b0;
    pwm_d        = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      duty_sh_d[i]  = duty_sh_q[i];
      duty_act_d[i] = duty_act_q[i];
      // Out-of-range channel indices never match any i, so they are dropped.
      if (wr_en && (32'(wr_ch) == i)) duty_sh_d[i] = wr_duty;
      pwm_d[i] = enable && (cnt_q < duty_act_q[i]);
    end

`ifdef PWM_CENTER_ALIGN_EN
    dir_d    = dir_q;
    en_d     = enable;
    boundary = enable && (!en_q || (period_act_q == '0) || (dir_q && (cnt_q == '0)));
`else
    boundary = enable && (cnt_q >= period_act_q);
`endif

    // Shadow bypass: a write in the load cycle lands directly in duty_act.
    if (!enable || boundary) begin
      period_act_d = period;
      for (int i = 0; i < CHANNELS; i++) duty_act_d[i] = duty_sh_d[i];
    end

    if (!enable) begin
      cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d = 1'b0;
`endif
    end else if (boundary) begin
      cnt_d        = '0;
      period_end_d = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d        = 1'b0;
`endif
    end else begin
`ifdef PWM_CENTER_ALIGN_EN
      // Count holds one cycle at each turn, so every value 0..P-1 occurs twice
      // per period (2*P cycles) and pulses are symmetric about the valley.
      if (!dir_q) begin
        if (cnt_q >= period_act_q - 1'b1) dir_d = 1'b1;
        else                              cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
`else
      cnt_d = cnt_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      period_act_q <= '0;
      pwm_q        <= '0;
      period_end_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
`ifdef PWM_CENTER_ALIGN_EN
      dir_q        <= 1'b0;
      en_q         <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      period_act_q <= period_act_d;
      pwm_q        <= pwm_d;
      period_end_q <= period_end_d;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh_q[i]  <= duty_sh_d[i];
        duty_act_q[i] <= duty_act_d[i];
      end
`ifdef PWM_CENTER_ALIGN_EN
      dir_q        <= dir_d;
      en_q         <= en_d;
`endif
    end
  end

  assign pwm        = pwm_q;
  assign period_end = period_end_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_gen_multi
// Brief    : Directed self-checking bench for pwm_gen_multi (both counter modes).
// Revision : 1.0
// ============================================================================
module tb_pwm_gen_multi;

  localparam int CHANNELS = 8;
  localparam int CNT_W    = 8;
  localparam int CH_W     = 4;

  logic                clk     = 1'b0;
  logic                rst_n   = 1'b0;
  logic                enable  = 1'b0;
  logic [CNT_W-1:0]    period  = '0;
  logic                wr_en   = 1'b0;
  logic [CH_W-1:0]     wr_ch   = '0;
  logic [CNT_W-1:0]    wr_duty = '0;
  logic [CHANNELS-1:0] pwm;
  logic                period_end;

  int n_checks = 0;
  int n_errors = 0;
  int hi_cnt  [CHANNELS];
  int exp_duty[CHANNELS];
  int pe_cnt;

  pwm_gen_multi #(
    .CHANNELS (CHANNELS),
    .CNT_W    (CNT_W),
    .CH_W     (CH_W)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .period     (period),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_duty    (wr_duty),
    .pwm        (pwm),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_acc();
    for (int i = 0; i < CHANNELS; i++) hi_cnt[i] = 0;
    pe_cnt = 0;
  endtask

  // One clock; optional duty write presented for that edge; samples 1 ns after.
  task automatic step(input bit we = 1'b0, input int ch = 0, input int duty = 0);
    wr_en   = we;
    wr_ch   = CH_W'(ch);
    wr_duty = CNT_W'(duty);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    for (int i = 0; i < CHANNELS; i++) if (pwm[i] === 1'b1) hi_cnt[i]++;
    if (period_end === 1'b1) pe_cnt++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic check_chans(input string tag);
    for (int i = 0; i < CHANNELS; i++)
      check($sformatf("%s ch%0d", tag, i), hi_cnt[i], exp_duty[i]);
  endtask

  function automatic int hi_sum();
    int s = 0;
    for (int i = 0; i < CHANNELS; i++) s += hi_cnt[i];
    return s;
  endfunction

  initial begin
    #2;
    check("reset pwm", pwm, 0);
    check("reset period_end", period_end, 0);
    #4 rst_n = 1'b1;
    clr_acc();
    run(5);
    check("idle pwm highs", hi_sum(), 0);
    check("idle period_end", pe_cnt, 0);

`ifdef PWM_CENTER_ALIGN_EN
    period = 8'd10;
    step(1'b1, 0, 4);
    step();
    enable = 1'b1;
    clr_acc();
    step();
    check("ctr first boundary", period_end, 1);
    run(19);
    check("ctr w1 ch0 highs", hi_cnt[0], 8);
    check("ctr w1 period_end", pe_cnt, 1);
    clr_acc();
    step(1'b1, 1, 10);
    run(19);
    check("ctr w2 ch0 highs", hi_cnt[0], 8);
    check("ctr w2 ch1 highs", hi_cnt[1], 0);
    check("ctr w2 period_end", pe_cnt, 1);
    clr_acc();
    run(20);
    check("ctr w3 ch0 highs", hi_cnt[0], 8);
    check("ctr w3 ch1 full", hi_cnt[1], 20);
    check("ctr w3 period_end", pe_cnt, 1);
`else
    period = 8'd99;
    for (int i = 0; i < CHANNELS; i++) step(1'b1, i, 10 * (i + 1));
    step();
    enable = 1'b1;

    exp_duty = '{10, 20, 30, 40, 50, 60, 70, 80};
    clr_acc();
    run(100);
    check_chans("basic w1");
    check("basic w1 period_end", pe_cnt, 1);
    check("basic w1 last pe", period_end, 1);
    clr_acc();
    run(100);
    check_chans("basic w2");
    check("basic w2 period_end", pe_cnt, 1);

    // mid-period write: current period unchanged
    clr_acc();
    run(40);
    step(1'b1, 0, 75);
    run(59);
    check("mid write ch0 same period", hi_cnt[0], 10);
    check("mid write period_end", pe_cnt, 1);

    // write in the boundary cycle
    clr_acc();
    run(99);
    step(1'b1, 1, 33);
    check("bnd write ch0 new", hi_cnt[0], 75);
    check("bnd write ch1 old", hi_cnt[1], 20);

    // extremes plus ignored out-of-range writes
    clr_acc();
    step(1'b1, 2, 0);
    step(1'b1, 3, 200);
    step(1'b1, 9, 55);
    step(1'b1, 8, 66);
    run(96);
    check("ext w1 ch1 bypass", hi_cnt[1], 33);
    check("ext w1 ch2 old", hi_cnt[2], 30);
    exp_duty = '{75, 33, 0, 100, 50, 60, 70, 80};
    clr_acc();
    run(100);
    check_chans("ext w2");
    check("ext w2 period_end", pe_cnt, 1);

    // disable mid-period for 5 cycles, write while disabled
    clr_acc();
    run(30);
    enable = 1'b0;
    clr_acc();
    step();
    step(1'b1, 4, 5);
    run(3);
    check("disabled pwm highs", hi_sum(), 0);
    check("disabled period_end", pe_cnt, 0);
    enable = 1'b1;
    exp_duty = '{75, 33, 0, 100, 5, 60, 70, 80};
    clr_acc();
    run(100);
    check_chans("reenable");
    check("reenable period_end", pe_cnt, 1);

    // period=0 takes effect at the next boundary
    period = 8'd0;
    clr_acc();
    step(1'b1, 0, 1);
    run(99);
    check("p0 pending ch0", hi_cnt[0], 75);
    check("p0 pending period_end", pe_cnt, 1);
    clr_acc();
    run(10);
    check("p0 ch0 high", hi_cnt[0], 10);
    check("p0 ch2 low", hi_cnt[2], 0);
    check("p0 period_end", pe_cnt, 10);

    // asynchronous reset mid-run
    #3 rst_n = 1'b0;
    #1;
    check("async rst pwm", pwm, 0);
    check("async rst period_end", period_end, 0);
    enable = 1'b0;
    #1 rst_n = 1'b1;
    clr_acc();
    run(5);
    check("post rst idle pwm", hi_sum(), 0);
    check("post rst idle pe", pe_cnt, 0);
    period = 8'd3;
    enable = 1'b1;
    clr_acc();
    run(8);
    check("post rst duties cleared", hi_sum(), 0);
    check("post rst period_end", pe_cnt, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
